deriv_term_eval: RTL and testbench



---
 rtl/calc_pkg.sv | 15 +
 rtl/deriv_term_eval_if.sv | 22 ++
 rtl/deriv_term_eval_term_mul_sat.sv | 23 ++
 rtl/deriv_term_eval.sv | 102 ++++++++++
 tb/tb_deriv_term_eval.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and default widths for the derivative-term evaluator.
package calc_pkg;
  localparam int COEF_W = 8;
  localparam int EXP_W  = 8;
  localparam int X_W    = 4;
  localparam int RES_W  = 16;

  localparam logic [RES_W-1:0] RES_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/deriv_term_eval_if.sv
// Term-in / result-out handshake bundle; master is the term source and result sink.
interface deriv_term_eval_if;
  logic                         in_valid;
  logic                         in_ready;
  logic [calc_pkg::COEF_W-1:0]  coef_in;
  logic [calc_pkg::EXP_W-1:0]   exp_in;
  logic [calc_pkg::X_W-1:0]     x_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [calc_pkg::RES_W-1:0]   result;
  logic                         overflow;

  modport master (
    output in_valid, coef_in, exp_in, x_in, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, coef_in, exp_in, x_in, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/deriv_term_eval_term_mul_sat.sv
// Combinational acc*x step with sticky overflow; clamps to all-ones when
// DERIV_EVAL_SATURATE_EN is defined, otherwise wraps modulo 2^RES_W.
module term_mul_sat
  import calc_pkg::*;
(
  input  logic [RES_W-1:0] acc_i,
  input  logic [X_W-1:0]   x_i,
  input  logic             ovf_i,
  output logic [RES_W-1:0] acc_o,
  output logic             ovf_o
);
  logic [RES_W+X_W-1:0] prod;

  always_comb begin
    prod  = {{X_W{1'b0}}, acc_i} * {{RES_W{1'b0}}, x_i};
    ovf_o = ovf_i | (|prod[RES_W+X_W-1:RES_W]);
`ifdef DERIV_EVAL_SATURATE_EN
    acc_o = ovf_o ? RES_MAX : prod[RES_W-1:0];
`else
    acc_o = prod[RES_W-1:0];
`endif
  end
endmodule

// File: rtl/deriv_term_eval.sv
// Evaluates coef * x^exp with one multiply per clock; out_valid exp+1 cycles after accept.
// Result held stable in DONE until out_ready; DERIV_EVAL_SATURATE_EN selects clamp vs wrap.
module deriv_term_eval
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  deriv_term_eval_if.slave bus
);
  state_e             state_q, state_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [EXP_W-1:0]   cnt_q, cnt_d;
  logic [X_W-1:0]     x_q, x_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [RES_W-1:0]   mul_acc;
  logic               mul_ovf;

  term_mul_sat u_mul (
    .acc_i (acc_q),
    .x_i   (x_q),
    .ovf_i (ovf_q),
    .acc_o (mul_acc),
    .ovf_o (mul_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d        = bus.x_in;
          acc_d      = {{(RES_W-COEF_W){1'b0}}, bus.coef_in};
          cnt_d      = bus.exp_in;
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
          // A zero exponent or zero coefficient already has its final value.
          if (bus.exp_in == '0 || bus.coef_in == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        acc_d = mul_acc;
        ovf_d = mul_ovf;
        cnt_d = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = acc_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_deriv_term_eval.sv
// Table vectors, hand-written corner sequences and random terms against a plain-arithmetic model.
module tb_deriv_term_eval;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deriv_term_eval_if dif();

  deriv_term_eval dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int coef;
    int ex;
    int x;
    int res_wrap;
    int ovf;
    int lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: true value of coef*x^k tracked against 2^16, low 16 bits tracked modulo.
  task automatic model(input int c, input int e, input int x,
                       output logic [15:0] r, output logic o, output int l);
    longint t;
    longint m;
    t = c;
    m = c;
    o = 1'b0;
    for (int k = 0; k < e; k++) begin
      m = (m * x) % 65536;
      t = t * x;
      if (t > 65535) begin
        o = 1'b1;
        t = 65536;
      end
    end
`ifdef DERIV_EVAL_SATURATE_EN
    r = o ? 16'hFFFF : m[15:0];
`else
    r = m[15:0];
`endif
    l = (c == 0 || e == 0) ? 1 : e + 1;
  endtask

  task automatic run_term(input int c, input int e, input int x,
                          input logic [15:0] er, input logic eo, input int el,
                          input int hold, input string tag);
    int w;
    int lat;
    logic [15:0] junk;
    dif.coef_in  = c[7:0];
    dif.exp_in   = e[7:0];
    dif.x_in     = x[3:0];
    dif.in_valid = 1'b1;
    w = 0;
    while (!dif.in_ready && w < 300) begin
      tick();
      w++;
    end
    chk($sformatf("%s accept_timeout", tag), 32'(w < 300), 32'd1);
    tick();
    dif.in_valid = 1'b0;
    lat = 1;
    while (!dif.out_valid && lat < 400) begin
      tick();
      lat++;
    end
    chk($sformatf("%s latency", tag), 32'(lat), 32'(el));
    chk($sformatf("%s result", tag), 32'(dif.result), 32'(er));
    chk($sformatf("%s overflow", tag), 32'(dif.overflow), 32'(eo));
    chk($sformatf("%s in_ready_busy", tag), 32'(dif.in_ready), 32'd0);
    // Stall the consumer while a new term is offered; nothing may move.
    for (int h = 0; h < hold; h++) begin
      junk = 16'($urandom);
      dif.out_ready = 1'b0;
      dif.in_valid  = 1'b1;
      dif.coef_in   = junk[7:0];
      dif.exp_in    = junk[15:8];
      dif.x_in      = junk[3:0];
      tick();
      chk($sformatf("%s hold%0d result", tag, h), 32'(dif.result), 32'(er));
      chk($sformatf("%s hold%0d overflow", tag, h), 32'(dif.overflow), 32'(eo));
      chk($sformatf("%s hold%0d out_valid", tag, h), 32'(dif.out_valid), 32'd1);
      chk($sformatf("%s hold%0d in_ready", tag, h), 32'(dif.in_ready), 32'd0);
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
    chk($sformatf("%s out_valid_drop", tag), 32'(dif.out_valid), 32'd0);
    chk($sformatf("%s in_ready_back", tag), 32'(dif.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] er;
    logic        eo;
    int          el;
    int          seen;
    int          c;
    int          e;
    int          x;

    vecs[0] = '{6,   1,   5,  30,     0, 2};
    vecs[1] = '{3,   0,   9,  3,      0, 1};
    vecs[2] = '{0,   7,   15, 0,      0, 1};
    vecs[3] = '{255, 2,   15, 'hE01F, 0, 3};
    vecs[4] = '{255, 3,   15, 'h21D1, 1, 4};
    vecs[5] = '{7,   5,   0,  0,      0, 6};
    vecs[6] = '{200, 9,   1,  200,    0, 10};
    vecs[7] = '{4,   2,   3,  36,     0, 3};
    vecs[8] = '{1,   255, 1,  1,      0, 256};
    vecs[9] = '{2,   16,  2,  0,      1, 17};

    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.coef_in   = '0;
    dif.exp_in    = '0;
    dif.x_in      = '0;
    rst_n         = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("reset in_ready", 32'(dif.in_ready), 32'd1);
    chk("reset out_valid", 32'(dif.out_valid), 32'd0);
    chk("reset result", 32'(dif.result), 32'd0);
    chk("reset overflow", 32'(dif.overflow), 32'd0);

    foreach (vecs[i]) begin
`ifdef DERIV_EVAL_SATURATE_EN
      er = (vecs[i].ovf != 0) ? 16'hFFFF : 16'(vecs[i].res_wrap);
`else
      er = 16'(vecs[i].res_wrap);
`endif
      run_term(vecs[i].coef, vecs[i].ex, vecs[i].x, er, vecs[i].ovf != 0,
               vecs[i].lat, 0, $sformatf("vec%0d", i));
    end

    run_term(9, 2, 2, 16'd36, 1'b0, 3, 10, "backpressure");

    // Reset in the middle of a long term.
    dif.coef_in  = 8'd2;
    dif.exp_in   = 8'd200;
    dif.x_in     = 4'd1;
    dif.in_valid = 1'b1;
    tick();
    dif.in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 49; k++) begin
      if (dif.out_valid) seen++;
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst in_ready", 32'(dif.in_ready), 32'd1);
    chk("midrst out_valid", 32'(dif.out_valid), 32'd0);
    chk("midrst result", 32'(dif.result), 32'd0);
    chk("midrst overflow", 32'(dif.overflow), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (dif.out_valid) seen++;
      tick();
    end
    chk("midrst no_out_valid", 32'(seen), 32'd0);
    run_term(4, 2, 3, 16'd36, 1'b0, 3, 0, "post_rst");

    for (int n = 0; n < 40; n++) begin
      c = int'($urandom_range(0, 255));
      e = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 6));
      x = int'($urandom_range(0, 15));
      model(c, e, x, er, eo, el);
      run_term(c, e, x, er, eo, el, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
